crossing_frame_controller: RTL and testbench

Frame-level sequencer between the camera pixel stream and the `pattern_recognition` pipeline. It aligns the pipeline to start-of-frame and gates exactly one frame of pixels into it. It waits, with a timeout, for that frame's detection result, then debounces per-frame `crossing_detected` results into a stable `crossing_confirmed` using an N-of-M vote with hysteresis. Downstream navigation logic reads only the confirmed flag and frame statistics.

---
 rtl/crossing_ctrl_pkg.sv | 24 ++
 rtl/crossing_vote_filter.sv | 56 +++++
 rtl/crossing_frame_controller.sv | 190 +++++++++++++++++++
 tb/tb_crossing_frame_controller.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossing_ctrl_pkg.sv
// Shared types and helpers for the crossing frame controller and its vote filter.
package crossing_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RESULT,
    DECIDE
  } ctrl_state_t;

  localparam int FRAME_CNT_W = 16;
  localparam int POP_MAX_W   = 8;

  // Vote windows are at most 8 frames, so a fixed 8-bit input covers every HIST.
  function automatic logic [3:0] popcount(input logic [POP_MAX_W-1:0] bits);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + {3'b000, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/crossing_vote_filter.sv
// N-of-M debounce of per-frame detections: shift history, popcount, hysteresis.
module crossing_vote_filter
  import crossing_ctrl_pkg::*;
#(
  parameter  int HIST      = 4,
  parameter  int ON_VOTES  = 3,
  parameter  int OFF_VOTES = 1,
  localparam int VCW       = $clog2(HIST + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vote,
  input  logic           vote_valid,
  output logic [VCW-1:0] vote_count,
  output logic           confirmed
);

  logic [HIST-1:0]      hist_q;
  logic [HIST-1:0]      hist_d;
  logic [VCW-1:0]       count_q;
  logic                 confirmed_q;
  logic                 confirmed_d;
  logic [POP_MAX_W-1:0] hist_ext;
  logic [3:0]           pop;

  always_comb begin
    hist_d      = hist_q << 1;
    hist_d[0]   = vote;
    hist_ext    = '0;
    hist_ext[HIST-1:0] = hist_d;
    pop         = popcount(hist_ext);
    confirmed_d = confirmed_q;
    // Between the two thresholds the previous decision holds.
    if (pop >= 4'(ON_VOTES)) begin
      confirmed_d = 1'b1;
    end else if (pop <= 4'(OFF_VOTES)) begin
      confirmed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q      <= '0;
      count_q     <= '0;
      confirmed_q <= 1'b0;
    end else if (vote_valid) begin
      hist_q      <= hist_d;
      count_q     <= VCW'(pop);
      confirmed_q <= confirmed_d;
    end
  end

  assign vote_count = count_q;
  assign confirmed  = confirmed_q;

endmodule

// File: rtl/crossing_frame_controller.sv
// Frame sequencer: aligns to SOF, gates one frame into pattern_recognition,
// waits for its result with a timeout, and debounces the crossing decision.
//
// state       | meaning
// IDLE        | drop non-SOF beats, hold the SOF beat and arm a frame
// STREAM      | zero-latency pass-through of exactly PIX_N beats
// WAIT_RESULT | wait for pr_detection_valid or the timeout
// DECIDE      | one cycle: vote into history, update statistics
module crossing_frame_controller
  import crossing_ctrl_pkg::*;
#(
  parameter  int IMG_WIDTH      = 320,
  parameter  int IMG_HEIGHT     = 240,
  parameter  int W              = 8,
  parameter  int HIST           = 4,
  parameter  int ON_VOTES       = 3,
  parameter  int OFF_VOTES      = 1,
  parameter  int RESULT_TIMEOUT = 4096,
  localparam int PIX_N          = IMG_WIDTH * IMG_HEIGHT,
  localparam int CW             = $clog2(PIX_N),
  localparam int VCW            = $clog2(HIST + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [W-1:0]           src_data,
  input  logic                   src_sof,
  output logic                   pr_x_valid,
  input  logic                   pr_x_ready,
  output logic [W-1:0]           pr_x_data,
  input  logic                   pr_detection_valid,
  input  logic                   pr_crossing_detected,
  input  logic [CW-1:0]          pr_white_count,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [CW-1:0]          last_white_count,
  output logic [VCW-1:0]         vote_count,
  output logic                   crossing_confirmed,
  output logic                   timeout_err,
  output logic                   sof_err
);

  localparam int            TW       = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;
  localparam logic [CW-1:0] PIX_LAST = CW'(PIX_N - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(RESULT_TIMEOUT - 1);

  ctrl_state_t            state_q;
  ctrl_state_t            state_d;
  logic [CW-1:0]          pix_q;
  logic [CW-1:0]          pix_d;
  logic [TW-1:0]          tmo_q;
  logic [TW-1:0]          tmo_d;
  logic                   vote_q;
  logic                   vote_d;
  logic [CW-1:0]          white_q;
  logic [CW-1:0]          white_d;
  logic                   timeout_err_q;
  logic                   timeout_err_d;
  logic                   sof_err_q;
  logic                   sof_err_d;
  logic                   frame_done_q;
  logic [FRAME_CNT_W-1:0] frame_count_q;
  logic [CW-1:0]          last_white_q;
  logic                   xfer;
  logic                   decide;

  assign xfer   = src_valid & pr_x_ready;
  assign decide = (state_q == DECIDE);

  always_comb begin
    state_d       = state_q;
    pix_d         = pix_q;
    tmo_d         = tmo_q;
    vote_d        = vote_q;
    white_d       = white_q;
    timeout_err_d = timeout_err_q;
    sof_err_d     = sof_err_q;
    src_ready     = 1'b0;
    pr_x_valid    = 1'b0;
    pr_x_data     = '0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          // The SOF beat is not accepted here; it is the first beat of STREAM.
          src_ready = ~(src_valid & src_sof);
          if (src_valid & src_sof) begin
            state_d = STREAM;
            pix_d   = '0;
          end
        end
      end
      STREAM: begin
        pr_x_valid = src_valid;
        pr_x_data  = src_data;
        src_ready  = pr_x_ready;
        if (xfer) begin
          if (src_sof && (pix_q != '0)) begin
            sof_err_d = 1'b1;
          end
          if (pix_q == PIX_LAST) begin
            pix_d   = '0;
            tmo_d   = TMO_LOAD;
            state_d = WAIT_RESULT;
          end else begin
            pix_d = pix_q + CW'(1);
          end
        end
      end
      WAIT_RESULT: begin
        if (pr_detection_valid) begin
          vote_d  = pr_crossing_detected;
          white_d = pr_white_count;
          state_d = DECIDE;
        end else if (tmo_q == '0) begin
          timeout_err_d = 1'b1;
          vote_d        = 1'b0;
          white_d       = '0;
          state_d       = DECIDE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      DECIDE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs stay low for the whole reset pulse, not just after the edge.
    if (rst) begin
      src_ready  = 1'b0;
      pr_x_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pix_q         <= '0;
      tmo_q         <= '0;
      vote_q        <= 1'b0;
      white_q       <= '0;
      timeout_err_q <= 1'b0;
      sof_err_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      last_white_q  <= '0;
    end else begin
      state_q       <= state_d;
      pix_q         <= pix_d;
      tmo_q         <= tmo_d;
      vote_q        <= vote_d;
      white_q       <= white_d;
      timeout_err_q <= timeout_err_d;
      sof_err_q     <= sof_err_d;
      frame_done_q  <= decide;
      if (decide) begin
        frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
        last_white_q  <= white_q;
      end
    end
  end

  crossing_vote_filter #(
    .HIST      (HIST),
    .ON_VOTES  (ON_VOTES),
    .OFF_VOTES (OFF_VOTES)
  ) u_vote_filter (
    .clk        (clk),
    .rst        (rst),
    .vote       (vote_q),
    .vote_valid (decide),
    .vote_count (vote_count),
    .confirmed  (crossing_confirmed)
  );

  assign busy             = (state_q != IDLE);
  assign frame_done       = frame_done_q;
  assign frame_count      = frame_count_q;
  assign last_white_count = last_white_q;
  assign timeout_err      = timeout_err_q;
  assign sof_err          = sof_err_q;

endmodule

// File: tb/tb_crossing_frame_controller.sv
// Randomized bench for crossing_frame_controller against a frame-level reference model.
module tb_crossing_frame_controller;

  localparam int IMG_WIDTH      = 4;
  localparam int IMG_HEIGHT     = 2;
  localparam int W              = 8;
  localparam int HIST           = 4;
  localparam int ON_VOTES       = 3;
  localparam int OFF_VOTES      = 1;
  localparam int RESULT_TIMEOUT = 16;
  localparam int PIX_N          = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW             = $clog2(PIX_N);
  localparam int VCW            = $clog2(HIST + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic           src_valid = 1'b0;
  logic           src_ready;
  logic [W-1:0]   src_data = '0;
  logic           src_sof = 1'b0;
  logic           pr_x_valid;
  logic           pr_x_ready = 1'b1;
  logic [W-1:0]   pr_x_data;
  logic           pr_detection_valid = 1'b0;
  logic           pr_crossing_detected = 1'b0;
  logic [CW-1:0]  pr_white_count = '0;
  logic           busy;
  logic           frame_done;
  logic [15:0]    frame_count;
  logic [CW-1:0]  last_white_count;
  logic [VCW-1:0] vote_count;
  logic           crossing_confirmed;
  logic           timeout_err;
  logic           sof_err;

  crossing_frame_controller #(
    .IMG_WIDTH      (IMG_WIDTH),
    .IMG_HEIGHT     (IMG_HEIGHT),
    .W              (W),
    .HIST           (HIST),
    .ON_VOTES       (ON_VOTES),
    .OFF_VOTES      (OFF_VOTES),
    .RESULT_TIMEOUT (RESULT_TIMEOUT)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .src_valid            (src_valid),
    .src_ready            (src_ready),
    .src_data             (src_data),
    .src_sof              (src_sof),
    .pr_x_valid           (pr_x_valid),
    .pr_x_ready           (pr_x_ready),
    .pr_x_data            (pr_x_data),
    .pr_detection_valid   (pr_detection_valid),
    .pr_crossing_detected (pr_crossing_detected),
    .pr_white_count       (pr_white_count),
    .busy                 (busy),
    .frame_done           (frame_done),
    .frame_count          (frame_count),
    .last_white_count     (last_white_count),
    .vote_count           (vote_count),
    .crossing_confirmed   (crossing_confirmed),
    .timeout_err          (timeout_err),
    .sof_err              (sof_err)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not seen within cycle budget (t=%0t)", name, $time);
  endtask

  // Reference model: phase of the frame, beats seen, cycles waited, vote history (newest first).
  int         ph = 0;
  int         beats = 0;
  int         waited = 0;
  int         hist[$];
  int         m_done = 0;
  int         m_conf = 0;
  int         m_tmo = 0;
  int         m_sof = 0;
  int         m_fc = 0;
  int         m_lw = 0;
  int         cap_vote = 0;
  int         cap_white = 0;
  int         done_seen = 0;
  logic [W-1:0] got_q[$];
  bit         bp_en = 1'b0;

  function automatic int vsum();
    int s;
    s = 0;
    foreach (hist[i]) s += hist[i];
    return s;
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst) begin
      ph = 0; beats = 0; waited = 0; hist.delete();
      m_done = 0; m_conf = 0; m_tmo = 0; m_sof = 0; m_fc = 0; m_lw = 0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(m_done));
      chk("busy", 32'(busy), 32'(ph != 0));
      chk("vote_count", 32'(vote_count), 32'(vsum()));
      chk("confirmed", 32'(crossing_confirmed), 32'(m_conf));
      chk("frame_count", 32'(frame_count), 32'(m_fc % 65536));
      chk("last_white", 32'(last_white_count), 32'(m_lw));
      chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
      chk("sof_err", 32'(sof_err), 32'(m_sof));
      if (ph == 1) begin
        chk("stream_valid", 32'(pr_x_valid), 32'(src_valid));
        chk("stream_ready", 32'(src_ready), 32'(pr_x_ready));
        if (src_valid) chk("stream_data", 32'(pr_x_data), 32'(src_data));
      end else begin
        chk("pr_x_valid_idle", 32'(pr_x_valid), 32'd0);
        chk("src_ready_nostream", 32'(src_ready),
            32'((ph == 0) && enable && !(src_valid && src_sof)));
      end
      if (frame_done) done_seen++;
      if (pr_x_valid && pr_x_ready) got_q.push_back(pr_x_data);

      m_done = 0;
      case (ph)
        0: if (enable && src_valid && src_sof) begin ph = 1; beats = 0; end
        1: if (src_valid && pr_x_ready) begin
             if (src_sof && beats != 0) m_sof = 1;
             beats++;
             if (beats == PIX_N) begin ph = 2; waited = 0; end
           end
        2: if (pr_detection_valid) begin
             cap_vote = int'(pr_crossing_detected); cap_white = int'(pr_white_count); ph = 3;
           end else if (waited == RESULT_TIMEOUT - 1) begin
             m_tmo = 1; cap_vote = 0; cap_white = 0; ph = 3;
           end else begin
             waited++;
           end
        default: begin
          hist.push_front(cap_vote);
          if (hist.size() > HIST) void'(hist.pop_back());
          if (vsum() >= ON_VOTES) m_conf = 1;
          else if (vsum() <= OFF_VOTES) m_conf = 0;
          m_fc++;
          m_lw = cap_white;
          m_done = 1;
          ph = 0;
        end
      endcase
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    pr_x_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_beat(input logic [W-1:0] d, input bit sof);
    int k;
    src_valid = 1'b1; src_data = d; src_sof = sof;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (src_ready) break;
    end
    if (k == 200) bound_fail("src_handshake");
    @(posedge clk);
    #1;
    src_valid = 1'b0; src_sof = 1'b0;
  endtask

  task automatic run_frame(input int junk, input bit bp, input bit bad_sof, input bit drop_en,
                           input int res_delay, input bit res_vote, input logic [CW-1:0] res_white);
    logic [W-1:0] sent[$];
    logic [W-1:0] d;
    int target;
    int k;
    target = done_seen + 1;
    enable = 1'b1;
    got_q.delete();
    for (int j = 0; j < junk; j++) send_beat(W'($urandom), 1'b0);
    bp_en = bp;
    for (int i = 0; i < PIX_N; i++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      if (drop_en && i == 3) enable = 1'b0;
      pr_detection_valid   = ($urandom_range(0, 5) == 0);
      pr_crossing_detected = 1'($urandom);
      pr_white_count       = CW'($urandom);
      d = W'($urandom);
      sent.push_back(d);
      send_beat(d, (i == 0) || (bad_sof && i == 5));
    end
    pr_detection_valid = 1'b0;
    bp_en = 1'b0;
    repeat (res_delay) begin @(posedge clk); #1; end
    pr_crossing_detected = res_vote;
    pr_white_count       = res_white;
    pr_detection_valid   = 1'b1;
    @(posedge clk);
    #1;
    pr_detection_valid = 1'b0;
    for (k = 0; k < 300; k++) begin
      @(posedge clk);
      if (done_seen >= target) break;
    end
    #1;
    if (k == 300) bound_fail("frame_done_wait");
    chk("frame_beats", 32'(got_q.size()), 32'(PIX_N));
    for (int i = 0; i < PIX_N && i < got_q.size(); i++) chk("frame_data", 32'(got_q[i]), 32'(sent[i]));
    if (drop_en) begin
      chk("idle_ready_enable_low", 32'(src_ready), 32'd0);
      enable = 1'b1;
    end
  endtask

  initial begin
    enable = 1'b1;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_pr_x_valid", 32'(pr_x_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_vote_count", 32'(vote_count), 32'd0);
    chk("rst_confirmed", 32'(crossing_confirmed), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_sof_err", 32'(sof_err), 32'd0);
    chk("rst_last_white", 32'(last_white_count), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed sequence: votes 1,1,1,0,0 then a timed-out frame (vote 0), window of 4.
    run_frame(3, 1'b0, 1'b0, 1'b0, 2, 1'b1, 3'd5);
    chk("f1_vote_count", 32'(vote_count), 32'd1);
    chk("f1_confirmed", 32'(crossing_confirmed), 32'd0);
    chk("f1_last_white", 32'(last_white_count), 32'd5);
    run_frame(0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 3'd3);
    chk("f2_vote_count", 32'(vote_count), 32'd2);
    chk("f2_confirmed", 32'(crossing_confirmed), 32'd0);
    run_frame(1, 1'b1, 1'b0, 1'b0, RESULT_TIMEOUT - 1, 1'b1, 3'd7);
    chk("f3_vote_count", 32'(vote_count), 32'd3);
    chk("f3_confirmed", 32'(crossing_confirmed), 32'd1);
    chk("f3_result_beats_timeout", 32'(timeout_err), 32'd0);
    chk("f3_last_white", 32'(last_white_count), 32'd7);
    run_frame(0, 1'b0, 1'b1, 1'b1, 4, 1'b0, 3'd2);
    chk("f4_vote_count", 32'(vote_count), 32'd3);
    chk("f4_confirmed", 32'(crossing_confirmed), 32'd1);
    chk("f4_sof_err", 32'(sof_err), 32'd1);
    run_frame(2, 1'b1, 1'b0, 1'b0, 1, 1'b0, 3'd6);
    chk("f5_vote_count", 32'(vote_count), 32'd2);
    chk("f5_confirmed_holds", 32'(crossing_confirmed), 32'd1);
    chk("f5_frame_count", 32'(frame_count), 32'd5);
    run_frame(0, 1'b0, 1'b0, 1'b0, 30, 1'b1, 3'd4);
    chk("f6_timeout_err", 32'(timeout_err), 32'd1);
    chk("f6_last_white", 32'(last_white_count), 32'd0);
    chk("f6_vote_count", 32'(vote_count), 32'd1);
    chk("f6_confirmed_clears", 32'(crossing_confirmed), 32'd0);
    chk("f6_frame_count", 32'(frame_count), 32'd6);

    for (int f = 0; f < 40; f++) begin
      int dly;
      dly = $urandom_range(0, 19);
      if ($urandom_range(0, 5) == 0) dly = RESULT_TIMEOUT - 1;
      run_frame($urandom_range(0, 3), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 5) == 0), dly, 1'($urandom_range(0, 1)), CW'($urandom));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    // Asynchronous reset in the middle of a frame.
    enable = 1'b1; src_data = 8'h3C; src_sof = 1'b1; src_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_src_ready", 32'(src_ready), 32'd0);
    chk("arst_pr_x_valid", 32'(pr_x_valid), 32'd0);
    chk("arst_vote_count", 32'(vote_count), 32'd0);
    chk("arst_confirmed", 32'(crossing_confirmed), 32'd0);
    src_valid = 1'b0; src_sof = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    src_data = 8'h77; src_valid = 1'b1;
    got_q.delete();
    repeat (6) @(posedge clk);
    #1;
    chk("no_fwd_without_sof", 32'(got_q.size()), 32'd0);
    chk("idle_after_reset", 32'(busy), 32'd0);
    src_valid = 1'b0;
    run_frame(1, 1'b1, 1'b0, 1'b0, 3, 1'b1, 3'd2);
    chk("post_rst_frame_count", 32'(frame_count), 32'd1);
    chk("post_rst_vote_count", 32'(vote_count), 32'd1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
